sram_axil_bridge: RTL and testbench

//  Memory-side responder for the core's SRAM-like fetch/data port (en/wen/addr/wdata -> rdata/stall).

---
 rtl/sram_axil_bridge_pkg.sv | 22 ++
 rtl/sram_axil_bridge.sv | 194 +++++++++++++++++++
 tb/tb_sram_axil_bridge.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axil_bridge_pkg.sv
// Shared encodings for the SRAM-port to AXI4-Lite bridge.
// FSM states, AXI response codes and default size/prot values.
package sram_axil_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_WORD    = 3'b010;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/sram_axil_bridge.sv
// SRAM-like core port to single-beat AXI4-Lite master, one outstanding txn.
// Optional bus_err output enabled by defining SRAM_AXIL_BUS_ERR_EN.
module sram_axil_bridge
    import sram_axil_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  sram_en,
    input  logic [DATA_W/8-1:0]   sram_wen,
    input  logic [ADDR_W-1:0]     sram_addr,
    input  logic [DATA_W-1:0]     sram_wdata,
    output logic [DATA_W-1:0]     sram_rdata,
    output logic                  sram_stall,
    input  logic                  longest_stall,

    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,

    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,

    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,

    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
`ifdef SRAM_AXIL_BUS_ERR_EN
    ,
    output logic                  bus_err
`endif
);

    localparam int STRB_W = DATA_W / 8;

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_aw_done;
    logic                r_w_done;

    logic                w_req;
    logic                w_is_wr;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_aw_fin;
    logic                w_w_fin;

    assign w_req   = (r_state == ST_IDLE) && sram_en;
    assign w_is_wr = |sram_wen;

    assign w_ar_hs = arvalid && arready;
    assign w_r_hs  = rready && rvalid;
    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;
    assign w_b_hs  = bready && bvalid;

    // A channel counts as finished if it completed earlier or completes now.
    assign w_aw_fin = r_aw_done || w_aw_hs;
    assign w_w_fin  = r_w_done || w_w_hs;

    always_comb begin
        w_next     = r_state;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        sram_stall = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                sram_stall = sram_en;
                if (sram_en) begin
                    w_next = w_is_wr ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                sram_stall = 1'b1;
                arvalid    = 1'b1;
                if (arready) begin
                    w_next = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                sram_stall = 1'b1;
                rready     = 1'b1;
                if (rvalid) begin
                    w_next = ST_DONE;
                end
            end
            ST_WR: begin
                sram_stall = 1'b1;
                awvalid    = !r_aw_done;
                wvalid     = !r_w_done;
                if (w_aw_fin && w_w_fin) begin
                    w_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                sram_stall = 1'b1;
                bready     = 1'b1;
                if (bvalid) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!longest_stall) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_req) begin
                r_addr    <= sram_addr;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if (w_is_wr) begin
                    r_wdata <= sram_wdata;
                    r_wstrb <= sram_wen;
                end
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if (w_r_hs) begin
                r_rdata <= rdata;
            end
        end
    end

    assign araddr     = r_addr;
    assign awaddr     = r_addr;
    assign wdata      = r_wdata;
    assign wstrb      = r_wstrb;
    assign sram_rdata = r_rdata;

`ifdef SRAM_AXIL_BUS_ERR_EN
    logic r_bus_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= (w_r_hs && (rresp != AXI_RESP_OKAY))
                      || (w_b_hs && (bresp != AXI_RESP_OKAY));
        end
    end

    assign bus_err = r_bus_err;
`else
    // Response codes are deliberately ignored in this build.
    logic w_unused_resp;
    assign w_unused_resp = ^{rresp, bresp};
`endif

endmodule

// File: tb/tb_sram_axil_bridge.sv
// Directed table-driven bench for sram_axil_bridge with a cycle-stepped AXI slave.
// Define SRAM_AXIL_BUS_ERR_EN to also check the bus_err pulse.
module tb_sram_axil_bridge;

    logic        clk;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_stall;
    logic        longest_stall;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
`ifdef SRAM_AXIL_BUS_ERR_EN
    logic        bus_err;
`endif

    sram_axil_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .sram_en       (sram_en),
        .sram_wen      (sram_wen),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .sram_stall    (sram_stall),
        .longest_stall (longest_stall),
        .araddr        (araddr),
        .arvalid       (arvalid),
        .arready       (arready),
        .rdata         (rdata),
        .rresp         (rresp),
        .rvalid        (rvalid),
        .rready        (rready),
        .awaddr        (awaddr),
        .awvalid       (awvalid),
        .awready       (awready),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .wvalid        (wvalid),
        .wready        (wready),
        .bresp         (bresp),
        .bvalid        (bvalid),
        .bready        (bready)
`ifdef SRAM_AXIL_BUS_ERR_EN
        ,
        .bus_err       (bus_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          ar_dly;
        int          aw_dly;
        int          w_dly;
        bit          hold;
        int          exp_stall;
        logic [31:0] exp_rdata;
        int          exp_berr;
    } vec_t;

    vec_t tbl[8];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'h0;
        rresp   = 2'b00;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int  stall_cyc = 0;
        int  ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
        int  ar_hs = 0, aw_hs = 0, w_hs = 0;
        int  viol = 0;
        int  berr = 0;
        bit  prev_arv = 0, prev_awv = 0, prev_wv = 0;
        bit  done = 0;
        bit  is_wr;
        string tag;
        is_wr = (v.wen != 4'b0000);
        tag = $sformatf("v%0d", idx);

        @(negedge clk);
        sram_en    = 1'b1;
        sram_wen   = v.wen;
        sram_addr  = v.addr;
        sram_wdata = v.wd;
        #1;
        for (int c = 0; c < 60 && !done; c++) begin
`ifdef SRAM_AXIL_BUS_ERR_EN
            if (bus_err) berr++;
`endif
            if (!sram_stall) begin
                done = 1;
            end else begin
                stall_cyc++;
                if (prev_arv && !arvalid) viol++;
                if (prev_awv && !awvalid) viol++;
                if (prev_wv && !wvalid) viol++;
                if (arvalid && araddr !== v.addr) viol++;
                if (awvalid && awaddr !== v.addr) viol++;
                if (wvalid && (wdata !== v.wd || wstrb !== v.wen)) viol++;
                if (rready && ar_hs == 0) viol++;
                if (!is_wr && (awvalid || wvalid || bready)) viol++;
                if (is_wr && (arvalid || rready)) viol++;
                arready = arvalid && (ar_cnt >= v.ar_dly);
                awready = awvalid && (aw_cnt >= v.aw_dly);
                wready  = wvalid && (w_cnt >= v.w_dly);
                rvalid  = rready;
                rdata   = v.rd;
                rresp   = v.resp;
                bvalid  = bready;
                bresp   = v.resp;
                if (arvalid && arready) ar_hs++;
                if (awvalid && awready) aw_hs++;
                if (wvalid && wready) w_hs++;
                if (arvalid && !arready) ar_cnt++;
                if (awvalid && !awready) aw_cnt++;
                if (wvalid && !wready) w_cnt++;
                prev_arv = arvalid && !arready;
                prev_awv = awvalid && !awready;
                prev_wv  = wvalid && !wready;
                @(negedge clk);
                #1;
            end
        end
        slave_idle();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_stall_cycles"}, 32'(stall_cyc), 32'(v.exp_stall));
        check({tag, "_rdata"}, sram_rdata, v.exp_rdata);
        check({tag, "_ar_hs"}, 32'(ar_hs), is_wr ? 32'd0 : 32'd1);
        check({tag, "_aw_hs"}, 32'(aw_hs), is_wr ? 32'd1 : 32'd0);
        check({tag, "_w_hs"}, 32'(w_hs), is_wr ? 32'd1 : 32'd0);
        check({tag, "_protocol"}, 32'(viol), 32'd0);

        if (v.hold) begin
            longest_stall = 1'b1;
            rdata  = 32'hFFFF_FFFF;
            rvalid = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                #1;
                check({tag, "_hold_rdata"}, sram_rdata, v.exp_rdata);
                check({tag, "_hold_stall"}, 32'(sram_stall), 32'd0);
                check({tag, "_hold_arvalid"}, 32'(arvalid), 32'd0);
            end
            longest_stall = 1'b0;
            slave_idle();
        end

        sram_en = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_idle_stall"}, 32'(sram_stall), 32'd0);
        check({tag, "_idle_valids"}, 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
`ifdef SRAM_AXIL_BUS_ERR_EN
        check({tag, "_bus_err_pulses"}, 32'(berr), 32'(v.exp_berr));
        check({tag, "_bus_err_after"}, 32'(bus_err), 32'd0);
`endif
    endtask

    initial begin
        //                wen      addr           wdata          slave rdata    resp   ar aw w  hold stall exp_rdata   berr
        tbl[0] = '{4'b0000, 32'h1FC0_0000, 32'h0,         32'h2402_0001, 2'b00, 0, 0, 0, 0, 3, 32'h2402_0001, 0};
        tbl[1] = '{4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         2'b00, 0, 0, 2, 0, 5, 32'h2402_0001, 0};
        tbl[2] = '{4'b0000, 32'h8000_0004, 32'h0,         32'h1234_5678, 2'b00, 4, 0, 0, 0, 7, 32'h1234_5678, 0};
        tbl[3] = '{4'b1111, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,         2'b00, 0, 3, 0, 0, 6, 32'h1234_5678, 0};
        tbl[4] = '{4'b0000, 32'h0000_1000, 32'h0,         32'h0BAD_F00D, 2'b00, 0, 0, 0, 1, 3, 32'h0BAD_F00D, 0};
        tbl[5] = '{4'b1100, 32'h0000_0300, 32'h0102_0304, 32'h0,         2'b00, 0, 0, 0, 0, 3, 32'h0BAD_F00D, 0};
        tbl[6] = '{4'b0000, 32'h0000_2000, 32'h0,         32'hA5A5_5A5A, 2'b10, 0, 0, 0, 0, 3, 32'hA5A5_5A5A, 1};
        tbl[7] = '{4'b0001, 32'h0000_0304, 32'h0000_00FF, 32'h0,         2'b10, 0, 1, 1, 0, 4, 32'hA5A5_5A5A, 1};

        resetn        = 1'b0;
        sram_en       = 1'b0;
        sram_wen      = 4'b0000;
        sram_addr     = 32'h0;
        sram_wdata    = 32'h0;
        longest_stall = 1'b0;
        slave_idle();
        repeat (3) @(negedge clk);
        #1;
        check("rst_rdata", sram_rdata, 32'h0);
        check("rst_stall", 32'(sram_stall), 32'd0);
        check("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
`ifdef SRAM_AXIL_BUS_ERR_EN
        check("rst_bus_err", 32'(bus_err), 32'd0);
`endif
        resetn = 1'b1;
        @(negedge clk);
        sram_en = 1'b1;
        #1;
        check("idle_comb_stall", 32'(sram_stall), 32'd1);
        sram_en = 1'b0;
        #1;
        check("idle_no_req_stall", 32'(sram_stall), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], i);
        end

        // Reset while the read is waiting for rvalid.
        @(negedge clk);
        sram_en   = 1'b1;
        sram_wen  = 4'b0000;
        sram_addr = 32'h0000_0040;
        @(negedge clk);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b0;
        #1;
        check("mid_rst_in_rd_data", 32'(rready), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_arvalid", 32'(arvalid), 32'd0);
        check("mid_rst_rready", 32'(rready), 32'd0);
        check("mid_rst_rdata", sram_rdata, 32'h0);
        check("mid_rst_stall_en1", 32'(sram_stall), 32'd1);
        sram_en = 1'b0;
        #1;
        check("mid_rst_stall_en0", 32'(sram_stall), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_txn('{4'b0000, 32'h0000_0044, 32'h0, 32'h5555_AAAA, 2'b00,
                  1, 0, 0, 0, 4, 32'h5555_AAAA, 0}, 8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
